hpm_counter_bank: RTL and testbench
===================================

// Module: hpm_counter_bank
// PURPOSE
//  Parametrised bank of RISC-V hardware performance-monitor counters: mhpmcounter3..(3+N-1), mhpmevent, mcountinhibit.
//  Adds Sscofpmf overflow flags, privilege-mode filtering and a local counter-overflow interrupt (LCOFI).
//  Sits beside the CSR unit. The CSR unit forwards decoded accesses with merged W/S/C write data; this block returns
//  read data, an access-fault flag and the lcof interrupt level for mip[13].
// PARAMETERS
//  NUM_COUNTERS   4   implemented HPM counters, 1..29; counter k maps to CSR index k+3
//  COUNTER_WIDTH  64  counter width, 32..64; bits above read zero, writes to them ignored
//  NUM_EVENTS     8   width of event input vector; event select 0 = never count
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: asynchronous, active-low
//  csr_valid     in   1       CSR access this cycle
//  csr_write     in   1       access writes (CSRRW, or CSRRS/C with nonzero source)
//  csr_addr      in   12      CSR address
//  csr_wdata     in   XLEN    final write value, already merged/masked by CSR unit
//  mode          in   2       current PrivMode (U=0, S=1, M=3)
//  mcounteren    in   32      counter-enable from M-mode
//  scounteren    in   32      counter-enable from S-mode
//  event_i       in   NUM_EVENTS  per-cycle event pulses, one bit per event source
//  csr_hit       out  1       csr_addr names a register in this bank (combinational)
//  csr_rdata     out  XLEN    read data (combinational; 0 when !csr_hit)
//  csr_illegal   out  1       csr_valid && csr_hit && access not permitted (combinational)
//  lcof_irq      out  1       registered OR of all overflow (OF) flags
// BEHAVIOUR
//  Reset: all counters 0, mhpmevent 0, mcountinhibit 0, lcof_irq 0, regardless of operation in flight.
//  Address map:
//   - 0x320 mcountinhibit: bits [3+N-1:3] writable, others read 0.
//   - 0xB03+k mhpmcounter: RW.
//   - 0x323+k mhpmevent: RW.
//   - 0xC03+k hpmcounter: RO shadow.
//   - Addresses in these ranges with k >= N: hit, read 0, writes dropped, legality rules unchanged.
//  mhpmevent WARL layout:
//   - [63] OF, [62] MINH, [61] SINH, [60] UINH.
//   - [EW-1:0] event select, EW = $clog2(NUM_EVENTS+1).
//   - All other bits read 0.
//  Access rules (illegal => no state change):
//   - 0x320, 0x323+, 0xB03+: require mode==M.
//   - 0xC03+k: writes always illegal.
//   - 0xC03+k reads: mode<M needs mcounteren[k+3]; mode==U also needs scounteren[k+3].
//  Increment condition for counter k, evaluated every cycle:
//   - sel!=0, sel<=NUM_EVENTS, event_i[sel-1]==1.
//   - !mcountinhibit[k+3].
//   - Mode filter not set: xINH bit for current mode clear (MINH/SINH/UINH).
//   - Increment is +1.
//  Overflow:
//   - Counter at 2^COUNTER_WIDTH-1 that increments wraps to 0 and sets OF on the same edge.
//   - lcof_irq rises the following cycle; OF is sticky until software writes 0.
//  Latency: a write or increment at edge t is visible on csr_rdata from cycle t+1.
//  Simultaneous events, same cycle:
//   - Legal write to mhpmcounter k beats its increment: written value stored, no +1, no OF set.
//   - Write to mhpmevent k clearing OF while counter k overflows: OF ends set.
//   - Write to mcountinhibit takes effect for increments from the next cycle.
// STRUCTURE
//  Shared package eei:
//   - CSR addresses MCOUNTINHIBIT, MHPMCOUNTER3, MHPMEVENT3, HPMCOUNTER3.
//   - MHPMEVENT_OF/MINH/SINH/UINH bit indices.
//   - Cause constant LOCAL_COUNTER_OVERFLOW_INTERRUPT = 13.
//  Sub-module hpm_counter_slice:
//   - Holds one counter plus its event register, increment/overflow logic and a write port.
//   - Generated NUM_COUNTERS times; the top does address decode, legality, read mux and lcof OR.
// TESTING
//  1. sel=2, pulse event_i[1] 5 cycles in M-mode -> mhpmcounter3 reads 5; counter4 (sel=0) reads 0.
//  2. Write mhpmcounter3=0xFFFF_FFFF_FFFF_FFFF, one event -> reads 0, mhpmevent3[63]=1, lcof_irq=1 next cycle;
//     write OF=0 -> lcof_irq 0.
//  3. COUNTER_WIDTH=40: write all-ones -> reads 0x00FF_FFFF_FFFF; one event wraps to 0 with OF set.
//  4. mode=U, mcounteren[3]=1, scounteren[3]=0: read 0xC03 -> csr_illegal=1;
//     set scounteren[3]=1 -> legal, value returned.
//  5. UINH=1, event stream in U then M -> count only M-mode cycles; mcountinhibit[3]=1 -> counter frozen.
//  6. Write to mhpmcounter3 and qualifying event same cycle -> written value exactly;
//     assert rst mid-stream -> all reads 0, lcof_irq 0.

Source files
------------

// File: rtl/hpm_counter_bank_pkg.sv
// Shared EEI constants for the HPM counter bank: CSR addresses, mhpmevent
// field positions, privilege-mode encodings and the LCOFI cause number.
package eei;

    localparam int XLEN = 64;

    localparam logic [11:0] MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] MHPMEVENT3    = 12'h323;
    localparam logic [11:0] MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] HPMCOUNTER3   = 12'hC03;

    localparam int MHPMEVENT_OF   = 63;
    localparam int MHPMEVENT_MINH = 62;
    localparam int MHPMEVENT_SINH = 61;
    localparam int MHPMEVENT_UINH = 60;

    localparam int LOCAL_COUNTER_OVERFLOW_INTERRUPT = 13;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_mode_e;

endpackage

// File: rtl/hpm_counter_bank_slice.sv
// One HPM counter with its mhpmevent register.
// Ports: clk/rst, event_i (event pulses), mode (current privilege),
// inhibit (mcountinhibit bit for this counter), cnt_we/evt_we + wdata
// (write port from the bank decoder), cnt_q/evt_q (XLEN-wide read views),
// of (sticky overflow flag).
module hpm_counter_slice
    import eei::*;
#(
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8,
    parameter int EW            = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic [1:0]            mode,
    input  logic                  inhibit,
    input  logic                  cnt_we,
    input  logic                  evt_we,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       cnt_q,
    output logic [XLEN-1:0]       evt_q,
    output logic                  of
);

    logic [COUNTER_WIDTH-1:0] cnt;
    logic [EW-1:0]            sel;
    logic                     minh, sinh, uinh;
    logic                     ev_hit, filtered, inc, ovf;
    logic                     unused_wdata;

    assign unused_wdata = ^wdata;

    // Select values above NUM_EVENTS never match any source.
    always_comb begin
        ev_hit = 1'b0;
        for (int i = 0; i < NUM_EVENTS; i++)
            if (sel == EW'(i + 1) && event_i[i]) ev_hit = 1'b1;
    end

    always_comb begin
        case (mode)
            PRIV_M:  filtered = minh;
            PRIV_S:  filtered = sinh;
            PRIV_U:  filtered = uinh;
            default: filtered = 1'b0;
        endcase
    end

    assign inc = ev_hit && !inhibit && !filtered;
    // A same-cycle software write to the counter suppresses both +1 and OF.
    assign ovf = inc && !cnt_we && (&cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            sel  <= '0;
            minh <= 1'b0;
            sinh <= 1'b0;
            uinh <= 1'b0;
            of   <= 1'b0;
        end else begin
            if (cnt_we)   cnt <= wdata[COUNTER_WIDTH-1:0];
            else if (inc) cnt <= cnt + 1'b1;
            if (evt_we) begin
                sel  <= wdata[EW-1:0];
                minh <= wdata[MHPMEVENT_MINH];
                sinh <= wdata[MHPMEVENT_SINH];
                uinh <= wdata[MHPMEVENT_UINH];
            end
            // Hardware overflow wins over a simultaneous software clear.
            if (ovf)         of <= 1'b1;
            else if (evt_we) of <= wdata[MHPMEVENT_OF];
        end
    end

    always_comb begin
        cnt_q = '0;
        cnt_q[COUNTER_WIDTH-1:0] = cnt;
        evt_q = '0;
        evt_q[EW-1:0]         = sel;
        evt_q[MHPMEVENT_OF]   = of;
        evt_q[MHPMEVENT_MINH] = minh;
        evt_q[MHPMEVENT_SINH] = sinh;
        evt_q[MHPMEVENT_UINH] = uinh;
    end

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of RISC-V HPM counters (mhpmcounter3.., mhpmevent3.., mcountinhibit)
// with Sscofpmf overflow flags and the LCOF interrupt level.
// Ports: clk, rst (async active-low); csr_valid/csr_write/csr_addr/csr_wdata
// (decoded access from the CSR unit); mode, mcounteren, scounteren (access
// gating); event_i (event pulses); csr_hit, csr_rdata, csr_illegal
// (combinational response); lcof_irq (registered OR of OF flags).
module hpm_counter_bank
    import eei::*;
#(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_valid,
    input  logic                  csr_write,
    input  logic [11:0]           csr_addr,
    input  logic [XLEN-1:0]       csr_wdata,
    input  logic [1:0]            mode,
    input  logic [31:0]           mcounteren,
    input  logic [31:0]           scounteren,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  csr_hit,
    output logic [XLEN-1:0]       csr_rdata,
    output logic                  csr_illegal,
    output logic                  lcof_irq
);

    localparam int          EW       = $clog2(NUM_EVENTS + 1);
    localparam logic [31:0] INH_MASK = ((32'd1 << NUM_COUNTERS) - 32'd1) << 3;

    logic [NUM_COUNTERS-1:0][XLEN-1:0] cnt_q, evt_q;
    logic [NUM_COUNTERS-1:0]           of, cnt_we, evt_we;
    logic [31:0]                       inh_q;
    logic [4:0]                        idx, k;
    logic                              is_inh, is_evt, is_cnt, is_shd;
    logic                              permitted, we_ok;

    // Low 5 address bits equal the mcounteren/mcountinhibit bit index (k+3).
    assign idx    = csr_addr[4:0];
    assign k      = idx - 5'd3;
    assign is_inh = (csr_addr == MCOUNTINHIBIT);
    assign is_evt = (csr_addr[11:5] == MHPMEVENT3[11:5])   && (idx >= 5'd3);
    assign is_cnt = (csr_addr[11:5] == MHPMCOUNTER3[11:5]) && (idx >= 5'd3);
    assign is_shd = (csr_addr[11:5] == HPMCOUNTER3[11:5])  && (idx >= 5'd3);

    assign csr_hit = is_inh || is_evt || is_cnt || is_shd;

    always_comb begin
        if (is_shd)
            permitted = !csr_write &&
                        (mode == PRIV_M ||
                         (mcounteren[idx] && (mode != PRIV_U || scounteren[idx])));
        else
            permitted = (mode == PRIV_M);
    end

    assign csr_illegal = csr_valid && csr_hit && !permitted;
    assign we_ok       = csr_valid && csr_write && csr_hit && permitted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_q    <= '0;
            lcof_irq <= 1'b0;
        end else begin
            if (we_ok && is_inh) inh_q <= csr_wdata[31:0] & INH_MASK;
            lcof_irq <= |of;
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_slice
        assign cnt_we[g] = we_ok && is_cnt && (k == 5'(g));
        assign evt_we[g] = we_ok && is_evt && (k == 5'(g));

        hpm_counter_slice #(
            .COUNTER_WIDTH(COUNTER_WIDTH),
            .NUM_EVENTS   (NUM_EVENTS),
            .EW           (EW)
        ) u_slice (
            .clk    (clk),
            .rst    (rst),
            .event_i(event_i),
            .mode   (mode),
            .inhibit(inh_q[g+3]),
            .cnt_we (cnt_we[g]),
            .evt_we (evt_we[g]),
            .wdata  (csr_wdata),
            .cnt_q  (cnt_q[g]),
            .evt_q  (evt_q[g]),
            .of     (of[g])
        );
    end

    // Unimplemented counters (k >= NUM_COUNTERS) fall through to zero.
    always_comb begin
        csr_rdata = '0;
        if (is_inh) csr_rdata[31:0] = inh_q;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (k == 5'(i)) begin
                if (is_evt)                csr_rdata = evt_q[i];
                else if (is_cnt || is_shd) csr_rdata = cnt_q[i];
            end
        end
    end

endmodule

// File: tb/tb_hpm_counter_bank.sv
module tb_hpm_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_valid = 1'b0, csr_write = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [1:0]  mode = 2'd3;
    logic [31:0] mcounteren = '0, scounteren = '0;
    logic [7:0]  event_i = '0;

    logic        hit, illegal, lcof;
    logic [63:0] rdata;
    logic        hit40, illegal40, lcof40;
    logic [63:0] rdata40;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hpm_counter_bank #(.NUM_COUNTERS(4), .COUNTER_WIDTH(64), .NUM_EVENTS(8)) dut (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_write(csr_write),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .mode(mode),
        .mcounteren(mcounteren), .scounteren(scounteren), .event_i(event_i),
        .csr_hit(hit), .csr_rdata(rdata), .csr_illegal(illegal), .lcof_irq(lcof));

    hpm_counter_bank #(.NUM_COUNTERS(4), .COUNTER_WIDTH(40), .NUM_EVENTS(8)) dut40 (
        .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_write(csr_write),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .mode(mode),
        .mcounteren(mcounteren), .scounteren(scounteren), .event_i(event_i),
        .csr_hit(hit40), .csr_rdata(rdata40), .csr_illegal(illegal40), .lcof_irq(lcof40));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        csr_valid = 1'b1; csr_write = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_valid = 1'b0; csr_write = 1'b0;
    endtask

    // Read on the 64-bit instance (which=0) or the 40-bit instance (which=1).
    task automatic rd(input string tag, input logic [11:0] a, input logic [63:0] exp,
                      input bit which = 0);
        csr_valid = 1'b1; csr_write = 1'b0; csr_addr = a;
        #1;
        chk(tag, which ? rdata40 : rdata, exp);
        tick();
        csr_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_lcof", {63'd0, lcof}, 64'd0);
        rd("rst_cnt3", 12'hB03, 64'd0);
        rst = 1'b1;
        tick();

        // 1: sel=2, five event cycles in M-mode
        wr(12'h323, 64'd2);
        event_i = 8'b10;
        repeat (5) tick();
        event_i = 8'b0;
        rd("t1_cnt3", 12'hB03, 64'd5);
        rd("t1_cnt4", 12'hB04, 64'd0);
        rd("t1_evt3", 12'h323, 64'd2);

        // 2/3: all-ones then one event -> wrap, OF, lcof next cycle
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("t3_cnt40_max", 12'hB03, 64'h0000_00FF_FFFF_FFFF, 1);
        rd("t2_cnt_max", 12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        event_i = 8'b10;
        tick();
        event_i = 8'b0;
        chk("t2_lcof_lag", {63'd0, lcof}, 64'd0);
        rd("t2_wrap", 12'hB03, 64'd0);
        chk("t2_lcof_set", {63'd0, lcof}, 64'd1);
        chk("t3_lcof40_set", {63'd0, lcof40}, 64'd1);
        rd("t2_of", 12'h323, 64'h8000_0000_0000_0002);
        rd("t3_wrap40", 12'hB03, 64'd0, 1);
        rd("t3_of40", 12'h323, 64'h8000_0000_0000_0002, 1);
        wr(12'h323, 64'd2);
        tick();
        chk("t2_lcof_clr", {63'd0, lcof}, 64'd0);

        // 4: shadow-read legality
        wr(12'hB03, 64'h1234);
        csr_valid = 1'b1; csr_write = 1'b1; csr_addr = 12'hC03; csr_wdata = 64'd9;
        #1;
        chk("t4_shd_wr_ill", {63'd0, illegal}, 64'd1);
        tick();
        csr_valid = 1'b0; csr_write = 1'b0;
        mode = 2'd0; mcounteren = 32'h8; scounteren = 32'h0;
        csr_valid = 1'b1; csr_addr = 12'hC03;
        #1;
        chk("t4_u_ill", {63'd0, illegal}, 64'd1);
        scounteren = 32'h8;
        #1;
        chk("t4_u_legal", {63'd0, illegal}, 64'd0);
        chk("t4_u_data", rdata, 64'h1234);
        csr_addr = 12'hB03;
        #1;
        chk("t4_u_mcnt_ill", {63'd0, illegal}, 64'd1);
        csr_valid = 1'b0;
        wr(12'hB03, 64'd77);          // dropped: U-mode
        mode = 2'd3;
        rd("t4_nochange", 12'hB03, 64'h1234);
        rd("t4_k_ge_n", 12'hB07, 64'd0);
        csr_addr = 12'h300;
        #1;
        chk("t4_nohit", {63'd0, hit}, 64'd0);

        // 5: UINH filter, then mcountinhibit
        wr(12'h323, 64'h1000_0000_0000_0002);
        wr(12'hB03, 64'd0);
        mode = 2'd0;
        event_i = 8'b10;
        repeat (3) @(posedge clk);
        #1 mode = 2'd3;
        repeat (4) @(posedge clk);
        #1 event_i = 8'b0;
        rd("t5_uinh", 12'hB03, 64'd4);
        wr(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("t5_inh_mask", 12'h320, 64'h78);
        wr(12'h320, 64'h8);
        event_i = 8'b10;
        repeat (3) tick();
        event_i = 8'b0;
        rd("t5_frozen", 12'hB03, 64'd4);
        wr(12'h320, 64'h0);

        // 6: write beats increment; OF set beats software clear
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        event_i = 8'b10;
        wr(12'hB03, 64'h100);
        event_i = 8'b0;
        rd("t6_wr_wins", 12'hB03, 64'h100);
        rd("t6_no_of", 12'h323, 64'h1000_0000_0000_0002);
        wr(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
        event_i = 8'b10;
        wr(12'h323, 64'd2);
        event_i = 8'b0;
        rd("t6_of_wins", 12'h323, 64'h8000_0000_0000_0002);
        chk("t6_lcof_pre", {63'd0, lcof}, 64'd1);

        // Asynchronous reset mid-stream
        event_i = 8'b10;
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_lcof", {63'd0, lcof}, 64'd0);
        rd("rst_mid_cnt", 12'hB03, 64'd0);
        rd("rst_mid_evt", 12'h323, 64'd0);
        rst = 1'b1;
        tick();
        rd("rst_after_cnt", 12'hB03, 64'd0);
        event_i = 8'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
